phy_rx_clk_align_ctrl: RTL
==========================

# phy_rx_clk_align_ctrl

Receive-side clock/phase controller for the PHY receiver. It owns a single 5-bit phase counter on `clk_32f` and derives the f/2f/4f divided clocks and one-cycle enable strobes from it. It searches the serial input for a comma byte and realigns the phase counter so that 4f periods coincide with byte boundaries. Once locked, it delivers aligned bytes to the rest of the receive path.

## Interface
Parameters:
- `COMMA`, 8'hBC: alignment byte, MSB received first.
- `MATCH_COUNT`, 4: consecutive boundary-aligned commas required for lock (2..7).

Ports:
- `clk_32f`  input  1  sole clock (bit rate).
- `reset`  input  1  **synchronous, active-high** reset.
- `enable`  input  1  search/lock permitted; low forces IDLE.
- `serial_in`  input  1  serial bit stream, one bit per `clk_32f`, MSB first.
- `clk_f`, `clk_2f`, `clk_4f`  output  1 each  50 % duty divided clocks (period 32/16/8 cycles).
- `en_f`, `en_2f`, `en_4f`  output  1 each  one-cycle strobe in the last cycle of each divided period.
- `data_out`  output  8  aligned byte (LOCKED only).
- `valid_out`  output  1  one-cycle pulse; `data_out` is new.
- `comma_out`  output  1  qualifies `valid_out`: `data_out == COMMA`.
- `active`  output  1  high while in LOCKED.

## Operation
- Phase counter `ph[4:0]`:
  - Increments mod 32 every cycle in all states.
  - Loaded to 0 on a realign event.
- Clock and strobe decodes are taken directly from register bits, so they are glitch-free:
  - `clk_4f = ~ph[2]`, `clk_2f = ~ph[3]`, `clk_f = ~ph[4]`.
  - `en_4f = (ph[2:0]==7)`, `en_2f = (ph[3:0]==15)`, `en_f = (ph==31)`.
  - "Boundary" means `en_4f` is high.
- Shift register: `sreg <= {sreg[6:0], serial_in}` every cycle. All comparisons use the registered `sreg`.
- FSM states are IDLE, SEARCH, CHECK and LOCKED.
  - **IDLE**: go to SEARCH when `enable` is high.
  - **SEARCH**: compare every cycle. If `sreg==COMMA`, then `ph<=0`, `cnt<=1` and go to CHECK.
  - **CHECK**: act at boundary only.
    - If `sreg==COMMA`, increment `cnt`. When `cnt` reaches `MATCH_COUNT`, go to LOCKED.
    - Otherwise set `cnt<=0` and go to SEARCH.
    - Off-boundary commas are ignored.
  - **LOCKED**: at each boundary, `data_out<=sreg`, `valid_out<=1` and `comma_out<=(sreg==COMMA)`.
    - Leaves LOCKED only on `reset` or `enable` low.
    - The comma that completes lock is not output.
- `enable` low in any state: next state IDLE, `cnt<=0`. `ph` keeps running.
- `active` is decoded from the state register.

## Timing
- Reset values (next edge with `reset`=1):
  - state IDLE, `ph`=0, `sreg`=0, `cnt`=0.
  - `data_out`=0, `valid_out`=0, `comma_out`=0, `active`=0.
  - Therefore `clk_f`/`clk_2f`/`clk_4f`=1 and `en_*`=0.
- Priority: `reset` > `enable` low > realign/boundary actions.
  - With `enable` low at a boundary in LOCKED, no `valid_out` is produced.
- Bit-to-compare latency: the last comma bit is presented at edge N and is in `sreg` after N.
  - A SEARCH match is acted on at edge N+1, which gives `ph`=0 after N+1.
  - The following byte's last bit lands at `ph`=7, which is the boundary.
- `valid_out` and `data_out` appear one cycle after the boundary (at `ph[2:0]==0`). They hold until the next capture, and `valid_out` lasts one cycle.
- `active` rises the cycle after the boundary holding the MATCH_COUNT-th comma. It falls the cycle after `reset` or `enable` low.
- The realign load may shorten the current divided-clock period. No pulse shorter than one `clk_32f` cycle is ever produced.

## Structure
- Shared package `phy_rx_pkg`:
  - state enum (2 bits).
  - `PH_W=5`.
  - default comma constant `8'hBC`.
- One natural sub-module, `phy_rx_phase_counter`:
  - Contents: the `ph` register plus the clock/strobe decodes.
  - Ports: `clk_32f`, `reset`, `realign` (load 0), all six clock/strobe outputs.
- FSM, `sreg`, `cnt` and the output registers stay in the top module.

## Test plan
1. Reset, then `enable`=0 for 64 cycles:
   - `clk_4f`/`clk_2f`/`clk_f` are high for 4/8/16 cycles after reset, with periods 8/16/32.
   - `en_4f` fires at `ph`=7,15,23,31.
   - `valid_out`=0, `active`=0.
2. Assert `enable` and send `0xBC` ×4 starting at a bit offset of 3:
   - First match gives `ph`=0.
   - `active`=1 one cycle after the 4th comma's boundary.
   - `en_4f` is coincident with each later byte's last bit.
3. Send `0xBC, 0xBC, 0x00`, then `0xBC` ×4:
   - Returns to SEARCH after `0x00`.
   - `active` stays 0 until the 4th comma of the second run, then rises.
4. Locked, send `0x5A, 0x3C, 0xBC`:
   - `data_out` = `0x5A`, `0x3C`, `0xBC`.
   - `valid_out` pulses 8 cycles apart.
   - `comma_out` = 0, 0, 1.
5. Locked, pulse `reset` mid-byte (and separately drop `enable`):
   - `active`=0 the next cycle and no `valid_out`.
   - After `reset`, `ph`=0, `data_out`=0 and the clocks are high.
6. In SEARCH, complete a comma when `ph`=13:
   - Next cycle `ph`=0, so `clk_4f` is high for the following 4 cycles and `en_4f` fires 8 cycles after the match.

Source files
------------

// File: rtl/phy_rx_pkg.sv
// Shared types and constants for the PHY receive clock/phase alignment block.
package phy_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } rx_state_e;

    localparam int          PH_W          = 5;
    localparam logic [7:0]  DEFAULT_COMMA = 8'hBC;

endpackage

// File: rtl/phy_rx_phase_counter.sv
// Free-running 5-bit phase counter on clk_32f with glitch-free divided clocks
// and end-of-period strobes decoded straight from its register bits.
module phy_rx_phase_counter
    import phy_rx_pkg::*;
(
    input  logic            clk_32f,
    input  logic            reset,
    input  logic            realign,
    output logic            clk_f,
    output logic            clk_2f,
    output logic            clk_4f,
    output logic            en_f,
    output logic            en_2f,
    output logic            en_4f,
    output logic [PH_W-1:0] ph_o
);

    logic [PH_W-1:0] ph_q;
    logic [PH_W-1:0] ph_d;

    // A realign restarts the byte period; it may cut the current one short.
    assign ph_d = (reset || realign) ? '0 : ph_q + PH_W'(1);

    always_ff @(posedge clk_32f) begin
        ph_q <= ph_d;
    end

    assign clk_4f = ~ph_q[2];
    assign clk_2f = ~ph_q[3];
    assign clk_f  = ~ph_q[4];
    assign en_4f  = &ph_q[2:0];
    assign en_2f  = &ph_q[3:0];
    assign en_f   = &ph_q;
    assign ph_o   = ph_q;

endmodule

// File: rtl/phy_rx_clk_align_ctrl.sv
// Receive clock/phase controller: hunts for the comma byte, aligns the phase
// counter to byte boundaries and delivers aligned bytes once locked.
module phy_rx_clk_align_ctrl
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COMMA       = DEFAULT_COMMA,
    parameter int         MATCH_COUNT = 4
) (
    input  logic            clk_32f,
    input  logic            reset,
    input  logic            enable,
    input  logic            serial_in,
    output logic            clk_f,
    output logic            clk_2f,
    output logic            clk_4f,
    output logic            en_f,
    output logic            en_2f,
    output logic            en_4f,
    output logic [7:0]      data_out,
    output logic            valid_out,
    output logic            comma_out,
    output logic            active,
    output rx_state_e       dbg_state_o,
    output logic [PH_W-1:0] dbg_ph_o
);

    localparam logic [2:0] MATCH_CNT = 3'(MATCH_COUNT);

    rx_state_e  state_q;
    logic [7:0] sreg_q;
    logic [2:0] cnt_q;
    logic [2:0] cnt_inc;
    logic [7:0] data_q;
    logic       valid_q;
    logic       comma_q;
    logic       is_comma;
    logic       realign;

    assign is_comma = (sreg_q == COMMA);
    assign cnt_inc  = cnt_q + 3'd1;
    // Only a SEARCH-state match moves the phase; enable low overrides it.
    assign realign  = (state_q == ST_SEARCH) && enable && is_comma;

    phy_rx_phase_counter u_phase (
        .clk_32f (clk_32f),
        .reset   (reset),
        .realign (realign),
        .clk_f   (clk_f),
        .clk_2f  (clk_2f),
        .clk_4f  (clk_4f),
        .en_f    (en_f),
        .en_2f   (en_2f),
        .en_4f   (en_4f),
        .ph_o    (dbg_ph_o)
    );

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            comma_q <= 1'b0;
        end else begin
            sreg_q  <= {sreg_q[6:0], serial_in};
            valid_q <= 1'b0;
            if (!enable) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_SEARCH;
                    ST_SEARCH: begin
                        if (is_comma) begin
                            cnt_q   <= 3'd1;
                            state_q <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        // Commas seen between boundaries are deliberately ignored.
                        if (en_4f) begin
                            if (is_comma) begin
                                cnt_q <= cnt_inc;
                                if (cnt_inc == MATCH_CNT) state_q <= ST_LOCKED;
                            end else begin
                                cnt_q   <= '0;
                                state_q <= ST_SEARCH;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (en_4f) begin
                            data_q  <= sreg_q;
                            valid_q <= 1'b1;
                            comma_q <= is_comma;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign comma_out   = comma_q;
    assign active      = (state_q == ST_LOCKED);
    assign dbg_state_o = state_q;

endmodule
